// File: rtl/crtc_mode_loader.sv
// Loads CRTC registers R0..R13 from a per-mode table through the index/data bus.
// Define CRTC_READBACK_EN to add a masked read-back check of every register.
module crtc_mode_loader #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       lock_req,
    input  logic [7:0] crtc_bus_in,
    output logic       crtc_cs,
    output logic       crtc_a0,
    output logic       crtc_write,
    output logic       crtc_read,
    output logic [7:0] crtc_bus,
    output logic       crtc_lock,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StIdx  = 3'd1;
    localparam logic [2:0] StGap1 = 3'd2;
    localparam logic [2:0] StDat  = 3'd3;
    localparam logic [2:0] StGap2 = 3'd4;
`ifdef CRTC_READBACK_EN
    localparam logic [2:0] StRd   = 3'd5;
    localparam logic [2:0] StChk  = 3'd6;
`endif
    localparam logic [2:0] StFin  = 3'd7;

    localparam logic [4:0] LastIndex = 5'd13;

    // R12 and R13 are zero for every mode, so only R0..R11 are tabulated.
    localparam logic [7:0] ModeTable [4][12] = '{
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07},
        '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C}
    };

    logic [2:0] state_q, state_d;
    logic [4:0] index_q, index_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] mode_q, mode_d;
    logic       error_q, error_d;
    logic [7:0] tbl_val;
    logic       gap_last;

`ifdef CRTC_READBACK_EN
    // Bits a real CRTC does not implement or read back are excluded from the check.
    localparam logic [7:0] RegMask [14] = '{
        8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h7F, 8'h1F, 8'h7F,
        8'h7F, 8'h00, 8'h1F, 8'h7F, 8'h1F, 8'h3F, 8'hFF
    };
    logic [7:0] rd_q, rd_d;
    logic [7:0] chk_mask;
    assign chk_mask = (index_q <= LastIndex) ? RegMask[index_q[3:0]] : 8'h00;
`else
    logic unused_bus_in;
    assign unused_bus_in = ^crtc_bus_in;
`endif

    assign tbl_val  = (index_q < 5'd12) ? ModeTable[mode_q][index_q[3:0]] : 8'h00;
    assign gap_last = (gap_q == 4'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        gap_d   = gap_q;
        mode_d  = mode_q;
        error_d = error_q;
`ifdef CRTC_READBACK_EN
        rd_d    = rd_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    error_d = 1'b0;
                    index_d = 5'd0;
                    state_d = StIdx;
                end
            end
            StIdx: begin
                gap_d   = 4'd0;
                state_d = StGap1;
            end
            StGap1: begin
                if (gap_last) state_d = StDat;
                else          gap_d   = gap_q + 4'd1;
            end
            StDat: begin
                gap_d   = 4'd0;
                state_d = StGap2;
            end
            StGap2: begin
                if (!gap_last) begin
                    gap_d = gap_q + 4'd1;
                end else begin
`ifdef CRTC_READBACK_EN
                    state_d = StRd;
`else
                    if (index_q == LastIndex) begin
                        state_d = StFin;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = StIdx;
                    end
`endif
                end
            end
`ifdef CRTC_READBACK_EN
            StRd: begin
                rd_d    = crtc_bus_in;
                state_d = StChk;
            end
            StChk: begin
                if (((rd_q ^ tbl_val) & chk_mask) != 8'h00) begin
                    error_d = 1'b1;
                    state_d = StFin;
                end else if (index_q == LastIndex) begin
                    state_d = StFin;
                end else begin
                    index_d = index_q + 5'd1;
                    state_d = StIdx;
                end
            end
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            index_q <= 5'd0;
            gap_q   <= 4'd0;
            mode_q  <= 2'd0;
            error_q <= 1'b0;
`ifdef CRTC_READBACK_EN
            rd_q    <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
            error_q <= error_d;
`ifdef CRTC_READBACK_EN
            rd_q    <= rd_d;
`endif
        end
    end

    always_comb begin
        crtc_cs    = 1'b0;
        crtc_a0    = 1'b0;
        crtc_write = 1'b0;
        crtc_read  = 1'b0;
        crtc_bus   = 8'h00;
        case (state_q)
            StIdx: begin
                crtc_cs    = 1'b1;
                crtc_write = 1'b1;
                crtc_bus   = {3'b000, index_q};
            end
            StDat: begin
                crtc_cs    = 1'b1;
                crtc_a0    = 1'b1;
                crtc_write = 1'b1;
                crtc_bus   = tbl_val;
            end
`ifdef CRTC_READBACK_EN
            StRd: begin
                crtc_cs   = 1'b1;
                crtc_a0   = 1'b1;
                crtc_read = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle) && (state_q != StFin);
    assign done      = (state_q == StFin);
    assign error     = error_q;
    assign crtc_lock = busy ? 1'b0 : lock_req;

endmodule

// File: tb/tb_crtc_mode_loader.sv
// Directed bench for crtc_mode_loader: bus-monitor capture plus immediate assertions.
module tb_crtc_mode_loader;

`ifdef CRTC_READBACK_EN
    localparam int PerReg = 6;
`else
    localparam int PerReg = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       lock_req = 1'b0;
    logic [7:0] crtc_bus_in;
    logic       crtc_cs, crtc_a0, crtc_write, crtc_read;
    logic [7:0] crtc_bus;
    logic       crtc_lock, busy, done, error;

    crtc_mode_loader #(.GAP_CYCLES(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .lock_req   (lock_req),
        .crtc_bus_in(crtc_bus_in),
        .crtc_cs    (crtc_cs),
        .crtc_a0    (crtc_a0),
        .crtc_write (crtc_write),
        .crtc_read  (crtc_read),
        .crtc_bus   (crtc_bus),
        .crtc_lock  (crtc_lock),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_tab [4][14] = '{
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07,
          8'h00, 8'h00},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07,
          8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07,
          8'h00, 8'h00},
        '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C,
          8'h00, 8'h00}
    };

    int n_checks = 0;
    int n_fail = 0;

    int busy_cnt, done_cnt, idx_writes, data_writes, rd_cnt, lock_bad;
    logic [7:0] idx_log [16];
    logic [7:0] data_log [16];
    logic [7:0] model_regs [16];
    logic [3:0] last_idx = 4'd0;
    bit corrupt_r4 = 1'b0;
    bit zero_r8 = 1'b1;

    // Behavioural CRTC: remembers written data and returns it on reads.
    assign crtc_bus_in = ((corrupt_r4 && last_idx == 4'd4) || (zero_r8 && last_idx == 4'd8))
                         ? 8'h00 : model_regs[last_idx];

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
            if (crtc_lock !== 1'b0) lock_bad++;
        end
        if (done === 1'b1) done_cnt++;
        if (crtc_read === 1'b1) rd_cnt++;
        if (crtc_cs === 1'b1 && crtc_write === 1'b1 && crtc_a0 === 1'b0) begin
            last_idx = crtc_bus[3:0];
            if (idx_writes < 16) idx_log[idx_writes] = crtc_bus;
            idx_writes++;
        end
        if (crtc_cs === 1'b1 && crtc_write === 1'b1 && crtc_a0 === 1'b1) begin
            data_log[last_idx] = crtc_bus;
            model_regs[last_idx] = crtc_bus;
            data_writes++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0; done_cnt = 0; idx_writes = 0; data_writes = 0; rd_cnt = 0; lock_bad = 0;
        for (int i = 0; i < 16; i++) begin
            idx_log[i] = 8'hEE;
            data_log[i] = 8'hEE;
            model_regs[i] = 8'h00;
        end
    endtask

    task automatic start_load(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_strobes"}, {28'd0, crtc_cs, crtc_a0, crtc_write, crtc_read}, 32'd0);
        chk({tag, "_bus"}, {24'd0, crtc_bus}, 32'd0);
        chk({tag, "_lock"}, {31'd0, crtc_lock}, {31'd0, lock_req});
    endtask

    initial begin
        clear_mon();
        lock_req = 1'b1;
        #12;
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 1 load: full write sequence and timing.
        clear_mon();
        start_load(2'd1);
        wait_done("m1_done_seen");
        chk("m1_idx_writes", idx_writes, 32'd14);
        chk("m1_data_writes", data_writes, 32'd14);
        chk("m1_r1", {24'd0, data_log[1]}, 32'h50);
        chk("m1_busy_len", busy_cnt, 32'(14 * PerReg));
        chk("m1_done_len", done_cnt, 32'd1);
        chk("m1_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("m1_idx%0d", i), {24'd0, idx_log[i]}, 32'(i));
            chk($sformatf("m1_data%0d", i), {24'd0, data_log[i]}, {24'd0, exp_tab[1][i]});
        end
`ifndef CRTC_READBACK_EN
        chk("m1_no_reads", rd_cnt, 32'd0);
`endif

        // Mode 3 load with lock requested.
        clear_mon();
        lock_req = 1'b1;
        start_load(2'd3);
        wait_done("m3_done_seen");
        chk("m3_r9", {24'd0, data_log[9]}, 32'h0D);
        chk("m3_r3", {24'd0, data_log[3]}, 32'h0F);
        chk("m3_lock_busy", lock_bad, 32'd0);
        chk("m3_lock_idle", {31'd0, crtc_lock}, 32'd1);
        lock_req = 1'b0;
        #1;
        chk("m3_lock_follow", {31'd0, crtc_lock}, 32'd0);

        // Start re-pulsed mid-load with a different mode is ignored.
        clear_mon();
        start_load(2'd3);
        repeat (9) @(negedge clk);
        mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_done_seen");
        chk("restart_idx_writes", idx_writes, 32'd14);
        chk("restart_busy_len", busy_cnt, 32'(14 * PerReg));
        chk("restart_r0", {24'd0, data_log[0]}, 32'h61);
        chk("restart_r4", {24'd0, data_log[4]}, 32'h19);
        chk("restart_r11", {24'd0, data_log[11]}, 32'h0C);

        // Reset during a load: outputs clear asynchronously and the load is abandoned.
        clear_mon();
        lock_req = 1'b1;
        start_load(2'd2);
        repeat (19) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset_no_done", done_cnt, 32'd0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);
        clear_mon();
        start_load(2'd2);
        wait_done("reload_done_seen");
        chk("reload_first_idx", {24'd0, idx_log[0]}, 32'd0);
        chk("reload_idx_writes", idx_writes, 32'd14);
        chk("reload_r4", {24'd0, data_log[4]}, 32'h7F);
        chk("reload_r6", {24'd0, data_log[6]}, 32'h64);

`ifdef CRTC_READBACK_EN
        // Corrupted R4 read-back aborts right after its check.
        clear_mon();
        corrupt_r4 = 1'b1;
        start_load(2'd0);
        wait_done("rb_done_seen");
        chk("rb_error", {31'd0, error}, 32'd1);
        chk("rb_done_len", done_cnt, 32'd1);
        chk("rb_busy_len", busy_cnt, 32'(5 * PerReg));
        chk("rb_idx_writes", idx_writes, 32'd5);
        repeat (3) @(negedge clk);
        chk("rb_error_sticky", {31'd0, error}, 32'd1);
        corrupt_r4 = 1'b0;
        clear_mon();
        start_load(2'd0);
        chk("rb_error_cleared", {31'd0, error}, 32'd0);
        wait_done("rb2_done_seen");
        chk("rb2_error", {31'd0, error}, 32'd0);
        chk("rb2_busy_len", busy_cnt, 32'(14 * PerReg));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crtc_mode_loader.md
CRTC_MODE_LOADER -- requirements
Module: crtc_mode_loader

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, giving the idle cycles after each bus strobe; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: load request, sampled in IDLE only.
REQ-005 SHALL have port mode, input, 2 bits: table select (0=40x25 text, 1=80x25 text, 2=320x200 graphics, 3=MDA 80x25).
REQ-006 SHALL have port lock_req, input, 1 bit: software lock request passed through while idle.
REQ-007 SHALL have port crtc_bus_in, input, 8 bits: CRTC read data, combinational from the CRTC.
REQ-008 SHALL have ports crtc_cs, crtc_a0, crtc_write, crtc_read, outputs, 1 bit each: CRTC bus strobes.
REQ-009 SHALL have port crtc_bus, output, 8 bits: CRTC write data.
REQ-010 SHALL have port crtc_lock, output, 1 bit: 0 while busy, otherwise equal to lock_req.
REQ-011 SHALL have ports busy, done and error, outputs, 1 bit each: status.

Function
REQ-012 SHALL on start=1 in IDLE latch mode, clear error and enter IDX for register index 0 on the same edge; start SHALL be ignored while busy.
REQ-013 SHALL load registers R0..R13 in ascending order.
REQ-014 SHALL visit states per register IDX -> GAP1 -> DAT -> GAP2; each GAP state SHALL last GAP_CYCLES cycles; IDX and DAT SHALL last 1 cycle each.
REQ-015 SHALL in IDX drive cs=1, a0=0, write=1, crtc_bus={3'b0,index}.
REQ-016 SHALL in DAT drive cs=1, a0=1, write=1, crtc_bus=table value.
REQ-017 SHALL in all other states drive cs=a0=write=read=0 and crtc_bus=0.
REQ-018 SHALL use these R0..R11 table values, with R12=R13=0x00 for all modes:
  mode0: 38 28 2D 0A 1F 06 19 1C 02 07 06 07
  mode1: 71 50 5A 0A 1F 06 19 1C 02 07 06 07
  mode2: 38 28 2D 0A 7F 06 64 70 02 01 06 07
  mode3: 61 50 52 0F 19 06 19 19 02 0D 0B 0C
REQ-019 SHALL after GAP2 of R13 enter FIN for 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-020 SHALL hold busy=1 in every state except IDLE and FIN.
REQ-021 SHALL assert done only in FIN.
REQ-022 SHALL hold error sticky until the next accepted start or reset.
REQ-023 SHALL ignore a change of mode during a load.

Reset
REQ-024 SHALL on reset_n=0 immediately force IDLE, busy=done=error=0, all strobes=0, crtc_bus=0, index=0.
REQ-025 SHALL while in reset force crtc_lock=lock_req.
REQ-026 SHALL leave a load that was interrupted by reset unfinished, with no resume.

Configuration
REQ-027 SHALL, with macro CRTC_READBACK_EN defined, append states RD then CHK after GAP2 of each register.
REQ-028 SHALL in RD drive cs=1, a0=1, read=1 for 1 cycle and register crtc_bus_in at the end of that cycle.
REQ-029 SHALL in CHK compare the registered read data to the table value under a per-register mask, for 1 cycle.
REQ-030 SHALL use these masks for R0..R13: FF FF FF 0F 7F 1F 7F 7F 00 1F 7F 1F 3F FF; mask 00 SHALL always pass.
REQ-031 SHALL on a CHK mismatch set error=1 and go directly to FIN.
REQ-032 SHALL, with CRTC_READBACK_EN undefined, contain no RD/CHK logic, keep crtc_read tied to 0 and never set error.

Verification
REQ-033 SHALL cover: default build, GAP_CYCLES=1, mode=1, start pulse -> 14 index/data write pairs; R1 data phase shows crtc_bus=0x50; busy high for exactly 56 cycles; done pulses for 1 cycle.
REQ-034 SHALL cover: mode=3 load -> R9 write value 0x0D and R3 write value 0x0F; crtc_lock=0 throughout busy, then equal to lock_req.
REQ-035 SHALL cover: start re-pulsed at busy cycle 10 with mode changed to 0 -> ignored; the sequence still completes with mode 3 values.
REQ-036 SHALL cover: reset_n low at busy cycle 20 -> all outputs 0 asynchronously; a new start after release begins again at R0.
REQ-037 SHALL cover: CRTC_READBACK_EN, behavioural CRTC model -> busy lasts 84 cycles with error=0; a model returning 0x00 for R8 still passes.
REQ-038 SHALL cover: CRTC_READBACK_EN, model corrupting R4 read data to 0x00 -> error=1, done at the cycle after R4 CHK, no index writes for R5..R13.
